// File: rtl/modn_cascade_counter.sv
// Chain of DIGITS digits, each counting modulo MODULUS. Supports up/down
// counting, synchronous clear, parallel load with range check, and a
// combinational carry_out so that instances can be cascaded on one clock.
module modn_cascade_counter #(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 2,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_value,
    output logic [DIGITS*WIDTH-1:0] out,
    output logic                    carry_out,
    output logic                    wrapped,
    output logic                    load_err
);

    // MODULUS always fits in WIDTH+1 bits because WIDTH >= $clog2(MODULUS).
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_DIGIT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] digit_q [DIGITS];
    logic [WIDTH-1:0] digit_d [DIGITS];
    logic             wrapped_q;
    logic             load_err_q;
    logic             terminal;
    logic             bad_load;

    // Next-state for every digit; lower_max/lower_zero ripple the
    // "all lower digits at the wrap value" condition up the chain.
    always_comb begin
        logic             lower_max;
        logic             lower_zero;
        logic             step_en;
        logic [WIDTH-1:0] ld_digit;
        lower_max  = 1'b1;
        lower_zero = 1'b1;
        step_en    = 1'b0;
        ld_digit   = '0;
        bad_load   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            ld_digit   = load_value[i*WIDTH +: WIDTH];
            step_en    = up_down ? lower_max : lower_zero;
            digit_d[i] = digit_q[i];
            if (clear) begin
                digit_d[i] = '0;
            end else if (load) begin
                if ({1'b0, ld_digit} < MOD_EXT) begin
                    digit_d[i] = ld_digit;
                end else begin
                    digit_d[i] = '0;
                    bad_load   = 1'b1;
                end
            end else if (enable) begin
                // An out-of-range digit is unreachable; recover to 0 if it happens.
                if ({1'b0, digit_q[i]} >= MOD_EXT) begin
                    digit_d[i] = '0;
                end else if (step_en) begin
                    if (up_down) begin
                        digit_d[i] = (digit_q[i] == MAX_DIGIT) ? '0 : digit_q[i] + 1'b1;
                    end else begin
                        digit_d[i] = (digit_q[i] == '0) ? MAX_DIGIT : digit_q[i] - 1'b1;
                    end
                end
            end
            lower_max  = lower_max  & (digit_q[i] == MAX_DIGIT);
            lower_zero = lower_zero & (digit_q[i] == '0);
        end
        terminal = up_down ? lower_max : lower_zero;
    end

    // Carry is same-cycle so a downstream instance steps on the wrap edge.
    assign carry_out = enable & terminal & ~clear & ~load;

    // Digit registers and one-cycle status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
            wrapped_q  <= carry_out;
            load_err_q <= bad_load;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_out
            assign out[g*WIDTH +: WIDTH] = digit_q[g];
        end
    endgenerate

    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

`ifndef SYNTHESIS
    // Parameter sanity and digit range invariants.
    a_params : assert property (@(posedge clock)
        (MODULUS >= 2) && (DIGITS >= 1) && (WIDTH >= $clog2(MODULUS)));

    generate
        for (g = 0; g < DIGITS; g++) begin : g_chk
            a_digit_range : assert property (@(posedge clock) disable iff (!reset)
                {1'b0, digit_q[g]} < MOD_EXT);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_modn_cascade_counter.sv
module tb_modn_cascade_counter;

    logic       clock;
    logic       reset;
    logic       enable, up_down, clear, load;
    logic [7:0] load_value;
    logic [7:0] out;
    logic       carry_out, wrapped, load_err;

    logic       c_enable, c_up_down, c_clear, c_load;
    logic [2:0] c_lo_out, c_hi_out;
    logic       c_lo_carry, c_hi_carry, c_lo_wrapped, c_hi_wrapped, c_lo_err, c_hi_err;

    int tests = 0;
    int fails = 0;

    modn_cascade_counter #(.MODULUS(10), .DIGITS(2), .WIDTH(4)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value), .out(out),
        .carry_out(carry_out), .wrapped(wrapped), .load_err(load_err)
    );

    modn_cascade_counter #(.MODULUS(6), .DIGITS(1), .WIDTH(3)) u_lo (
        .clock(clock), .reset(reset), .enable(c_enable), .up_down(c_up_down),
        .clear(c_clear), .load(c_load), .load_value(3'd0), .out(c_lo_out),
        .carry_out(c_lo_carry), .wrapped(c_lo_wrapped), .load_err(c_lo_err)
    );

    modn_cascade_counter #(.MODULUS(6), .DIGITS(1), .WIDTH(3)) u_hi (
        .clock(clock), .reset(reset), .enable(c_lo_carry), .up_down(c_up_down),
        .clear(c_clear), .load(c_load), .load_value(3'd0), .out(c_hi_out),
        .carry_out(c_hi_carry), .wrapped(c_hi_wrapped), .load_err(c_hi_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int k);
        return 8'(((k / 10) << 4) | (k % 10));
    endfunction

    function automatic int combined();
        return int'(c_hi_out) * 6 + int'(c_lo_out);
    endfunction

    initial begin
        int hi_wraps;
        reset = 1'b1; enable = 1'b1; up_down = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = 8'h00;
        c_enable = 1'b0; c_up_down = 1'b1; c_clear = 1'b0; c_load = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_wrapped", 32'(wrapped), 0);
        chk("rst_load_err", 32'(load_err), 0);
        chk("rst_carry", 32'(carry_out), 0);
        enable = 1'b0;
        step();
        reset = 1'b1;

        // reset mid-count at 37
        load = 1'b1; load_value = 8'h35; step();
        chk("load35", 32'(out), 32'h35);
        load = 1'b0; enable = 1'b1; step(); step();
        chk("count37", 32'(out), 32'h37);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'h00);
        chk("async_rst_wrapped", 32'(wrapped), 0);
        chk("async_rst_load_err", 32'(load_err), 0);
        enable = 1'b0;
        step();
        reset = 1'b1;

        // full up count 00..99 then wrap
        enable = 1'b1; up_down = 1'b1;
        for (int k = 1; k <= 99; k++) begin
            step();
            chk("up_count", 32'(out), 32'(bcd(k)));
            if (k == 98) chk("carry_at_98", 32'(carry_out), 0);
        end
        chk("carry_at_99", 32'(carry_out), 1);
        chk("no_wrap_at_99", 32'(wrapped), 0);
        step();
        chk("wrap_out", 32'(out), 32'h00);
        chk("wrap_pulse", 32'(wrapped), 1);
        chk("carry_after_wrap", 32'(carry_out), 0);
        enable = 1'b0; step();
        chk("wrap_pulse_end", 32'(wrapped), 0);

        // down counting and borrow
        load = 1'b1; load_value = 8'h50; step();
        chk("load50", 32'(out), 32'h50);
        load = 1'b0; enable = 1'b1; up_down = 1'b0;
        step(); chk("down49", 32'(out), 32'h49);
        step(); chk("down48", 32'(out), 32'h48);
        chk("down_no_wrap", 32'(wrapped), 0);
        enable = 1'b0; load = 1'b1; load_value = 8'h00; step();
        chk("load00", 32'(out), 32'h00);
        load = 1'b0; enable = 1'b1; #1;
        chk("borrow_carry", 32'(carry_out), 1);
        step();
        chk("borrow_out", 32'(out), 32'h99);
        chk("borrow_wrapped", 32'(wrapped), 1);
        enable = 1'b0; step();
        chk("borrow_wrap_end", 32'(wrapped), 0);

        // illegal load digit
        load = 1'b1; load_value = 8'hA3; step();
        chk("illegal_out", 32'(out), 32'h03);
        chk("illegal_err", 32'(load_err), 1);
        load = 1'b0; step();
        chk("illegal_err_end", 32'(load_err), 0);
        chk("illegal_hold", 32'(out), 32'h03);

        // priority clear > load > count
        load = 1'b1; load_value = 8'h42; step();
        chk("load42", 32'(out), 32'h42);
        clear = 1'b1; load = 1'b1; load_value = 8'h99; enable = 1'b1; up_down = 1'b1;
        step();
        chk("clear_wins", 32'(out), 32'h00);
        clear = 1'b0; enable = 1'b0; load_value = 8'h99; step();
        chk("load99", 32'(out), 32'h99);
        enable = 1'b1; load_value = 8'h17; #1;
        chk("carry_masked_load", 32'(carry_out), 0);
        clear = 1'b1; #1;
        chk("carry_masked_clear", 32'(carry_out), 0);
        clear = 1'b0;
        step();
        chk("load_no_incr", 32'(out), 32'h17);
        chk("load_no_wrap", 32'(wrapped), 0);
        load = 1'b0; up_down = 1'b0; step();
        chk("dir_down16", 32'(out), 32'h16);
        up_down = 1'b1; step();
        chk("dir_up17", 32'(out), 32'h17);
        enable = 1'b0;

        // cascaded mod-6 pair
        c_clear = 1'b1; step();
        c_clear = 1'b0;
        chk("chain_clear", 32'(combined()), 0);
        c_enable = 1'b1; c_up_down = 1'b1;
        hi_wraps = 0;
        for (int k = 1; k <= 72; k++) begin
            if (k % 36 == 0) chk("chain_carry35", 32'(c_hi_carry), 1);
            step();
            chk("chain_count", 32'(combined()), 32'(k % 36));
            if (c_hi_wrapped) hi_wraps++;
        end
        chk("chain_wraps", 32'(hi_wraps), 2);
        chk("chain_lo_err", 32'(c_lo_err), 0);
        chk("chain_hi_err", 32'(c_hi_err), 0);
        c_up_down = 1'b0;
        step(); chk("chain_down35", 32'(combined()), 35);
        chk("chain_down_wrap", 32'(c_hi_wrapped), 1);
        step(); chk("chain_down34", 32'(combined()), 34);
        c_up_down = 1'b1;
        step(); chk("chain_up35", 32'(combined()), 35);
        c_enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
